mem_access_ctrl: RTL and testbench



---
 rtl/mem_access_pkg.sv | 30 +++
 rtl/mem_lane_unit.sv | 43 ++++
 rtl/mem_access_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings and alignment helpers for the data-memory access sequencer.
package mem_access_pkg;

    localparam logic [2:0] T_W  = 3'd0;
    localparam logic [2:0] T_H  = 3'd1;
    localparam logic [2:0] T_HU = 3'd2;
    localparam logic [2:0] T_B  = 3'd3;
    localparam logic [2:0] T_BU = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } state_t;

    function automatic logic is_illegal_type(input logic [2:0] typ);
        return typ > T_BU;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] typ, input logic [1:0] addr_lo);
        case (typ)
            T_W:       return addr_lo != 2'b00;
            T_H, T_HU: return addr_lo[0];
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Little-endian lane extraction for loads and sub-word merge for stores.
module mem_lane_unit
    import mem_access_pkg::*;
(
    input  logic [2:0]  typ,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word_in,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [4:0]  bofs;

    always_comb begin
        half_sel   = addr_lo[1] ? word_in[31:16] : word_in[15:0];
        bofs       = {addr_lo, 3'b000};
        byte_sel   = word_in[bofs +: 8];
        load_val   = '0;
        store_word = word_in;
        case (typ)
            T_W: begin
                load_val   = word_in;
                store_word = wdata;
            end
            T_H, T_HU: begin
                load_val = {{16{(typ == T_H) & half_sel[15]}}, half_sel};
                if (addr_lo[1])
                    store_word[31:16] = wdata[15:0];
                else
                    store_word[15:0] = wdata[15:0];
            end
            T_B, T_BU: begin
                load_val = {{24{(typ == T_B) & byte_sel[7]}}, byte_sel};
                store_word[bofs +: 8] = wdata[7:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer driving a word-addressed synchronous RAM.
//
//   state  | meaning
//   IDLE   | req_ready high, waiting for a request
//   RD     | RAM read issued for a load or sub-word store
//   CAP    | ram_rdata valid; extract load value or build merged store word
//   WR     | RAM word write of the merge register
//   DONE   | one-cycle response pulse
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_type,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t      state;
    logic        lat_we;
    logic [2:0]  lat_type;
    logic [1:0]  lat_addr_lo;
    logic [31:0] lat_wdata;
    logic [31:0] load_val;
    logic [31:0] store_word;
    logic        req_bad;

    // Byte address bits above the RAM word range are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign req_bad = is_illegal_type(req_type) || is_misaligned(req_type, req_addr[1:0]);

    mem_lane_unit u_lane (
        .typ        (lat_type),
        .addr_lo    (lat_addr_lo),
        .word_in    (ram_rdata),
        .wdata      (lat_wdata),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            lat_we      <= 1'b0;
            lat_type    <= T_W;
            lat_addr_lo <= 2'b00;
            lat_wdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_we      <= req_we;
                        lat_type    <= req_type;
                        lat_addr_lo <= req_addr[1:0];
                        lat_wdata   <= req_wdata;
                        ram_addr    <= req_addr[ADDR_W+1:2];
                        req_ready   <= 1'b0;
                        if (req_bad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= S_DONE;
                        end else if (req_we && req_type == T_W) begin
                            // Full-word store needs no read; merge register is the store data.
                            ram_wdata <= req_wdata;
                            ram_en    <= 1'b1;
                            ram_we    <= 1'b1;
                            state     <= S_WR;
                        end else begin
                            ram_en <= 1'b1;
                            state  <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    ram_en <= 1'b0;
                    state  <= S_CAP;
                end
                S_CAP: begin
                    if (lat_we) begin
                        ram_wdata <= store_word;
                        ram_en    <= 1'b1;
                        ram_we    <= 1'b1;
                        state     <= S_WR;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_val;
                        state      <= S_DONE;
                    end
                end
                S_WR: begin
                    ram_en     <= 1'b0;
                    ram_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a byte-array memory model.
module tb_mem_access_ctrl;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_type = 3'd0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = '0;

    logic [31:0]   ram [0:(1<<AW)-1];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [31:0]   pre_data = '0;

    logic [7:0]    ref_b [0:(4<<AW)-1];

    int n_chk = 0;
    int n_err = 0;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_type   (req_type),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we)
            ram[pre_addr] <= pre_data;
        else if (ram_en) begin
            if (ram_we)
                ram[ram_addr] <= ram_wdata;
            else
                ram_rdata <= ram[ram_addr];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    function automatic logic ref_err(input logic [2:0] typ, input logic [31:0] addr);
        int lo;
        lo = int'(addr[1:0]);
        if (typ > 3'd4) return 1'b1;
        if (typ == 3'd0) return (lo % 4) != 0;
        if (typ == 3'd1 || typ == 3'd2) return (lo % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] typ, input logic [31:0] addr);
        int a;
        int v;
        a = int'(addr[12:0]);
        case (typ)
            3'd0: return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
            3'd1, 3'd2: begin
                v = int'(ref_b[a+1]) * 256 + int'(ref_b[a]);
                if (typ == 3'd1 && v >= 32768) v = v - 65536;
                return 32'(v);
            end
            default: begin
                v = int'(ref_b[a]);
                if (typ == 3'd3 && v >= 128) v = v - 256;
                return 32'(v);
            end
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] wdata);
        int a;
        int nb;
        a  = int'(addr[12:0]);
        nb = (typ == 3'd0) ? 4 : (typ <= 3'd2) ? 2 : 1;
        for (int i = 0; i < nb; i++) ref_b[a+i] = wdata[8*i +: 8];
    endtask

    task automatic preload(input int w, input logic [31:0] d);
        pre_addr = AW'(w);
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
        for (int i = 0; i < 4; i++) ref_b[4*w+i] = d[8*i +: 8];
    endtask

    // Entered and left at a falling edge; the following rising edge is the accept edge.
    task automatic run_req(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] wdata);
        logic        err_e, err_g;
        int          lat_e, en_e, we_e, lat_g, en_g, we_g, w;
        logic [31:0] rd_e, rd_g, wd_g, ra_g;
        w     = int'(addr[12:2]);
        err_e = ref_err(typ, addr);
        rd_e  = (err_e || we) ? 32'd0 : ref_load(typ, addr);
        if (err_e) begin lat_e = 1; en_e = 0; we_e = 0; end
        else if (!we) begin lat_e = 3; en_e = 1; we_e = 0; end
        else if (typ == 3'd0) begin lat_e = 2; en_e = 1; we_e = 1; end
        else begin lat_e = 4; en_e = 2; we_e = 3; end
        if (!err_e && we) ref_store(typ, addr, wdata);

        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_type  = typ;
        req_addr  = addr;
        req_wdata = wdata;
        lat_g = 0; en_g = 0; we_g = 0; rd_g = '0; err_g = 1'b0; wd_g = '0; ra_g = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (ram_en) begin
                if (en_g == 0) ra_g = 32'(ram_addr);
                en_g++;
            end
            if (ram_we) begin
                we_g = k;
                wd_g = ram_wdata;
            end
            if (resp_valid) begin
                lat_g = k;
                rd_g  = resp_rdata;
                err_g = resp_err;
                break;
            end
        end
        chk("latency", 32'(lat_g), 32'(lat_e));
        chk("resp_rdata", rd_g, rd_e);
        chk("resp_err", 32'(err_g), 32'(err_e));
        chk("ram_en_cycles", 32'(en_g), 32'(en_e));
        chk("ram_we_cycle", 32'(we_g), 32'(we_e));
        if (en_e > 0) chk("ram_addr", ra_g, 32'(w));
        if (we_e > 0) chk("ram_wdata", wd_g, ref_word(w));
        @(negedge clk);
        chk("resp_single_pulse", 32'(resp_valid), 32'd0);
        chk("resp_rdata_hold", resp_rdata, rd_e);
        chk("ram_word", ram[w], ref_word(w));
    endtask

    task automatic reset_mid_rmw();
        int we_n, rv_n;
        we_n = 0; rv_n = 0;
        req_valid = 1'b1; req_we = 1'b1; req_type = 3'd3;
        req_addr = 32'h11; req_wdata = 32'h5A5A5A77;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (k == 3) begin
                chk("rst_ready", 32'(req_ready), 32'd1);
                rst = 1'b0;
            end
            if (ram_we) we_n++;
            if (resp_valid) rv_n++;
            if (k == 2) rst = 1'b1;
        end
        chk("rst_no_write", 32'(we_n), 32'd0);
        chk("rst_no_resp", 32'(rv_n), 32'd0);
        chk("rst_ram_intact", ram[4], ref_word(4));
    endtask

    task automatic hold_valid_load();
        int en_n, rv_n, held, exp_acc;
        logic [31:0] exp_rd;
        held    = 8;
        exp_acc = (held + 3) / 4;
        exp_rd  = ref_load(3'd0, 32'h18);
        en_n = 0; rv_n = 0;
        req_valid = 1'b1; req_we = 1'b0; req_type = 3'd0; req_addr = 32'h18; req_wdata = '0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == held) req_valid = 1'b0;
            if (ram_en) en_n++;
            if (resp_valid) begin
                rv_n++;
                chk("hold_rdata", resp_rdata, exp_rd);
            end
        end
        chk("hold_accepts", 32'(en_n), 32'(exp_acc));
        chk("hold_resps", 32'(rv_n), 32'(exp_acc));
        chk("hold_ready_end", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] r, addr;
        logic [2:0]  typ;
        int          lo;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        for (int i = 0; i < 8; i++) preload(i, $urandom());
        rst = 1'b0;
        @(negedge clk);

        preload(4, 32'hDEADBEEF);
        run_req(1'b0, 3'd0, 32'h10, 32'h0);

        preload(4, 32'h80817F01);
        run_req(1'b0, 3'd3, 32'h13, 32'h0);
        run_req(1'b0, 3'd4, 32'h13, 32'h0);
        run_req(1'b0, 3'd1, 32'h12, 32'h0);
        run_req(1'b0, 3'd2, 32'h10, 32'h0);
        run_req(1'b0, 3'd3, 32'h10, 32'h0);

        run_req(1'b1, 3'd3, 32'h11, 32'h123456AA);
        run_req(1'b1, 3'd1, 32'h12, 32'h00001234);
        chk("sh_sb_word4", ram[4], 32'h1234AA01);

        run_req(1'b1, 3'd0, 32'h14, 32'hCAFEF00D);
        chk("sw_word5", ram[5], 32'hCAFEF00D);

        run_req(1'b0, 3'd0, 32'h13, 32'h0);
        run_req(1'b1, 3'd1, 32'h11, 32'hFFFFFFFF);
        run_req(1'b0, 3'd7, 32'h10, 32'h0);

        reset_mid_rmw();
        hold_valid_load();

        for (int n = 0; n < 60; n++) begin
            r    = $urandom();
            typ  = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            lo   = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) begin
                if (typ == 3'd0) lo = 0;
                else if (typ <= 3'd2) lo = lo & 2;
            end
            addr = (r & 32'hFFFFE000) | (32'($urandom_range(0, 7)) << 2) | 32'(lo);
            run_req(1'($urandom_range(0, 1)), typ, addr, $urandom());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
